// File: rtl/us_emu_pkg.sv
// us_emu_pkg: shared state encoding, counter widths and jitter LFSR constants
// for the ultrasonic echo emulator.
package us_emu_pkg;

    typedef enum logic [2:0] {IDLE, TRIG_HI, DELAY, ECHO, HOLDOFF} state_t;

    localparam int CNT_W = 16;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/us_tick_prescaler.sv
// us_tick_prescaler: emits a one-cycle tick every TICK_DIV enabled cycles,
// restartable from zero with i_clear.
module us_tick_prescaler
    import us_emu_pkg::*;
#(
    parameter int TICK_DIV = 50
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    localparam logic [CNT_W-1:0] L_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = i_enable && (r_cnt == L_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear)
            r_cnt <= '0;
        else if (i_enable)
            r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/us_echo_emulator.sv
// us_echo_emulator: sensor-side trigger/echo responder; echo width encodes dist_cm.
// Define US_EMU_JITTER_EN to add 0..7 ticks of LFSR jitter to each echo.
module us_echo_emulator
    import us_emu_pkg::*;
#(
    parameter int TICK_DIV      = 50,
    parameter int MIN_TRIG_US   = 10,
    parameter int ECHO_DELAY_US = 500,
    parameter int US_PER_CM     = 58,
    parameter int MAX_CM        = 400,
    parameter int MAX_ECHO_US   = 38000,
    parameter int HOLDOFF_US    = 1000
) (
    input  logic       CLK50MHZ,
    input  logic       resetn,
    input  logic       trig,
    input  logic [8:0] dist_cm,
    output logic       echo,
    output logic       busy,
    output logic       trig_err
);

    // The rise-detect cycle is not counted, so the threshold is one less
    localparam logic [CNT_W-1:0] L_MIN_W    = CNT_W'(MIN_TRIG_US * TICK_DIV - 1);
    localparam logic [CNT_W-1:0] L_DELAY    = CNT_W'(ECHO_DELAY_US);
    localparam logic [CNT_W-1:0] L_HOLDOFF  = CNT_W'(HOLDOFF_US);
    localparam logic [CNT_W-1:0] L_MAX_ECHO = CNT_W'(MAX_ECHO_US);
    localparam logic [8:0]       L_MAX_CM   = 9'(MAX_CM);

    state_t           r_state, w_next;
    logic [1:0]       r_sync;
    logic             r_ts_d, r_echo, r_trig_err;
    logic [CNT_W-1:0] r_width, r_ticks, r_echo_us;
    logic [CNT_W-1:0] w_base, w_echo_us, w_dur;
    logic             w_ts, w_rise, w_tick, w_done, w_err, w_accept, w_take;

    assign w_ts     = r_sync[1];
    assign w_rise   = w_ts && !r_ts_d;
    assign w_accept = r_width >= L_MIN_W;
    assign w_take   = (r_state == TRIG_HI) && !w_ts && w_accept;
    assign w_base   = (dist_cm == 9'd0 || dist_cm > L_MAX_CM) ? L_MAX_ECHO
                                                            : CNT_W'(dist_cm * US_PER_CM);
    assign w_dur    = (r_state == DELAY) ? L_DELAY : (r_state == ECHO) ? r_echo_us : L_HOLDOFF;
    assign w_done   = w_tick && (r_ticks == w_dur - 16'd1);

`ifdef US_EMU_JITTER_EN
    logic [7:0] r_lfsr;

    assign w_echo_us = w_base + {13'd0, r_lfsr[2:0]};

    always_ff @(posedge CLK50MHZ) begin
        if (!resetn)
            r_lfsr <= LFSR_SEED;
        else if (w_take)
            r_lfsr <= lfsr_next(r_lfsr);
    end
`else
    assign w_echo_us = w_base;
`endif

    us_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .i_clk    (CLK50MHZ),
        .i_rst_n  (resetn),
        .i_clear  (w_next != r_state),
        .i_enable (r_state inside {DELAY, ECHO, HOLDOFF}),
        .o_tick   (w_tick)
    );

    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        case (r_state)
            IDLE:    w_next = w_rise ? TRIG_HI : IDLE;
            TRIG_HI: begin
                w_next = w_ts ? TRIG_HI : (w_accept ? DELAY : IDLE);
                w_err  = !w_ts && !w_accept;
            end
            DELAY:   w_next = w_done ? ECHO : DELAY;
            ECHO:    w_next = w_done ? HOLDOFF : ECHO;
            HOLDOFF: w_next = w_done ? IDLE : HOLDOFF;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK50MHZ) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_sync     <= '0;
            r_ts_d     <= 1'b0;
            r_echo     <= 1'b0;
            r_trig_err <= 1'b0;
            r_width    <= '0;
            r_ticks    <= '0;
            r_echo_us  <= '0;
        end else begin
            r_state    <= w_next;
            r_sync     <= {r_sync[0], trig};
            r_ts_d     <= w_ts;
            r_echo     <= (w_next == ECHO);
            r_trig_err <= w_err;
            r_ticks    <= (w_next != r_state) ? '0 : r_ticks + CNT_W'(w_tick);
            if (r_state == IDLE && w_rise)
                r_width <= '0;
            else if (r_state == TRIG_HI && w_ts && r_width != '1)
                r_width <= r_width + 1'b1;
            if (w_take)
                r_echo_us <= w_echo_us;
        end
    end

    assign echo     = r_echo;
    assign busy     = (r_state != IDLE);
    assign trig_err = r_trig_err;

endmodule

// File: tb/tb_us_echo_emulator.sv
// tb_us_echo_emulator: directed and randomized trigger/echo transactions checked
// against an arithmetic model of the sensor timing, using scaled-down timing constants.
module tb_us_echo_emulator;

    localparam int T     = 4;
    localparam int MINW  = 10;
    localparam int D     = 20;
    localparam int UPC   = 3;
    localparam int MAXCM = 400;
    localparam int MAXE  = 1500;
    localparam int H     = 30;
    localparam int LIMIT = 10000;

    logic       clk = 1'b0, resetn = 1'b0, trig = 1'b0;
    logic [8:0] dist_cm = '0;
    logic       echo, busy, trig_err;
    int         tests = 0, fails = 0;
    logic [7:0] m_lfsr = 8'hA5;

    always #10 clk = ~clk;

    us_echo_emulator #(
        .TICK_DIV(T), .MIN_TRIG_US(MINW), .ECHO_DELAY_US(D), .US_PER_CM(UPC),
        .MAX_CM(MAXCM), .MAX_ECHO_US(MAXE), .HOLDOFF_US(H)
    ) dut (
        .CLK50MHZ(clk), .resetn(resetn), .trig(trig), .dist_cm(dist_cm),
        .echo(echo), .busy(busy), .trig_err(trig_err)
    );

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Expected echo high time in cycles for an accepted trigger
    task automatic expect_width(input logic [8:0] d, output int w);
        int us;
        us = (d == 0 || d > MAXCM) ? MAXE : int'(d) * UPC;
`ifdef US_EMU_JITTER_EN
        us += int'(m_lfsr[2:0]);
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
        w = us * T;
    endtask

    task automatic pulse(input int w, input logic [8:0] d, output int busy_at);
        dist_cm = d;
        trig = 1'b1;
        busy_at = -1;
        for (int i = 1; i <= w; i++) begin
            @(negedge clk);
            if (busy && busy_at < 0) busy_at = i;
        end
        trig = 1'b0;
    endtask

    task automatic wait_echo(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!echo && n < LIMIT);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_accept(input int w, input logic [8:0] d, input bit disturb);
        int ew, ba, n;
        expect_width(d, ew);
        pulse(w, d, ba);
        check("busy_rise", ba, 3);
        wait_echo(n);
        check("echo_latency", n, D * T + 3);
        n = 0;
        while (echo && n < LIMIT) begin
            if (disturb && n == 5) begin
                trig = 1'b1;
                dist_cm = 9'($urandom);
            end
            if (disturb && n == 5 + 2 * MINW * T) trig = 1'b0;
            @(negedge clk);
            n++;
        end
        trig = 1'b0;
        check("echo_width", n, ew);
        count_busy(n);
        check("holdoff", n, H * T);
    endtask

    task automatic run_reject(input int w);
        int ba, pat, n;
        pulse(w, 9'($urandom_range(1, 400)), ba);
        check("busy_rise_short", ba, 3);
        pat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            pat = pat | (int'(trig_err) << (i - 1)) | (int'(busy) << (i + 3));
        end
        check("trig_err_pattern", pat, 32'b0011_0100);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n += int'(echo) + int'(busy);
        end
        check("no_echo_after_reject", n, 0);
    endtask

    initial begin
        int ew, ba, n;
        repeat (3) @(negedge clk);
        check("reset_echo", int'(echo), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_trig_err", int'(trig_err), 0);
        resetn = 1'b1;
        @(negedge clk);

        run_accept(60, 9'd10, 1'b0);
        run_reject(30);
        run_accept(MINW * T, 9'd7, 1'b0);
        run_reject(MINW * T - 1);
        run_accept(50, 9'd0, 1'b0);
        run_accept(50, 9'd401, 1'b0);
        run_accept(50, 9'd400, 1'b0);
        run_accept(50, 9'd1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            run_accept($urandom_range(MINW * T, 200), 9'($urandom_range(0, 511)), 1'b0);
            run_reject($urandom_range(3, MINW * T - 1));
        end

        run_accept(60, 9'd200, 1'b1);

        // trig rises during holdoff and stays high into IDLE
        expect_width(9'd50, ew);
        pulse(60, 9'd50, ba);
        wait_echo(n);
        n = 0;
        while (echo && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("hold_echo_width", n, ew);
        n = 0;
        while (busy && n < LIMIT) begin
            if (n == 10) trig = 1'b1;
            @(negedge clk);
            n++;
        end
        check("hold_holdoff", n, H * T);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n += int'(echo) + int'(busy);
        end
        check("held_trig_ignored", n, 0);
        trig = 1'b0;
        repeat (5) @(negedge clk);
        run_accept(60, 9'd25, 1'b0);

        // reset during echo
        expect_width(9'd100, ew);
        pulse(60, 9'd100, ba);
        wait_echo(n);
        repeat (20) @(negedge clk);
        check("echo_before_reset", int'(echo), 1);
        resetn = 1'b0;
        @(negedge clk);
        check("reset_mid_echo", int'(echo), 0);
        check("reset_mid_busy", int'(busy), 0);
        resetn = 1'b1;
        m_lfsr = 8'hA5;
        @(negedge clk);
        run_accept(60, 9'd10, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/us_echo_emulator.md
# us_echo_emulator

Synthesizable responder for the ultrasonic ranging interface: it plays the sensor's side of the trigger/echo handshake. It accepts a trigger pulse on a pin, waits a fixed burst delay, then drives an echo pulse whose width encodes a programmed distance in centimetres. It stands in for the physical sensor in hardware-in-loop tests and in simulation of the distance-measuring controller. All timing is derived from the 50 MHz system clock.

## Interface
- TICK_DIV, 50: clock cycles per 1 us tick.
- MIN_TRIG_US, 10: minimum accepted trigger width.
- ECHO_DELAY_US, 500: burst delay from trigger fall to echo rise.
- US_PER_CM, 58: round-trip echo time per cm.
- MAX_CM, 400: largest in-range distance.
- MAX_ECHO_US, 38000: echo width for "no object".
- HOLDOFF_US, 1000: dead time after echo fall.
- CLK50MHZ input 1: system clock; all logic on rising edge.
- resetn input 1: synchronous, active-low reset.
- trig input 1: trigger pin; asynchronous to CLK50MHZ.
- dist_cm input 9: programmed distance; sampled at trigger acceptance.
- echo output 1: echo pin; registered.
- busy output 1: high in every state except IDLE.
- trig_err output 1: one-cycle pulse when a rejected short trigger ends.

## Operation
- Synchronizer: trig passes through 2 flops. The edge detector works on the synchronized value (ts).
- States:
  - IDLE: a rising edge of ts goes to TRIG_HI and clears the width counter.
  - TRIG_HI: count cycles while ts=1. The counter is 16 bits and saturates.
  - On the ts fall in TRIG_HI:
    - Width >= MIN_TRIG_US*TICK_DIV: accept. Latch dist_cm and go to DELAY.
    - Otherwise: pulse trig_err and go to IDLE.
  - DELAY: lasts ECHO_DELAY_US ticks, then goes to ECHO with echo=1.
  - ECHO: lasts echo_us ticks, then echo=0 and go to HOLDOFF.
  - HOLDOFF: lasts HOLDOFF_US ticks, then goes to IDLE.
- Echo width:
  - echo_us = latched dist_cm*US_PER_CM, computed as a 16-bit unsigned value (400*58=23200 fits).
  - If dist_cm==0 or dist_cm>MAX_CM: echo_us=MAX_ECHO_US.
- Tick prescaler: counts 0..TICK_DIV-1 and restarts at 0 on entry to DELAY, ECHO and HOLDOFF. Every duration is therefore an exact multiple of TICK_DIV cycles.
- Busy behaviour:
  - Trigger edges in DELAY, ECHO and HOLDOFF are ignored.
  - A trig held high across the HOLDOFF→IDLE transition is not accepted. A fresh rising edge seen while in IDLE is required.
- Changes on dist_cm after acceptance have no effect on the echo in progress.

## Timing
- Reset values: echo=0, busy=0, trig_err=0, state=IDLE, synchronizer flops=0, all counters=0.
- Reset mid-operation: echo is 0 from the clock edge that samples resetn=0.
- Echo rise: exactly ECHO_DELAY_US*TICK_DIV+3 cycles after the first edge that samples the trig pin low (2 synchronizer cycles + 1 edge-detect cycle).
- Echo high time: exactly echo_us*TICK_DIV cycles.
- busy: rises 3 cycles after the trig pin rise and falls HOLDOFF_US*TICK_DIV cycles after the echo fall.
- trig_err: 1 cycle wide, 3 cycles after the trig pin falls.

## Configuration
- US_EMU_JITTER_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded 8'hA5 on reset.
  - Echo width becomes echo_us + lfsr[2:0] ticks.
  - The LFSR advances once per accepted trigger, after its value is used.
- US_EMU_JITTER_EN undefined: no LFSR is present and the width is exactly echo_us.

## Structure
- Package us_emu_pkg:
  - state enum (IDLE, TRIG_HI, DELAY, ECHO, HOLDOFF).
  - LFSR seed and tap constants.
  - counter width localparams (16-bit width/tick counters).
- Sub-module us_tick_prescaler:
  - Inputs: clear, enable.
  - Output: a one-cycle tick every TICK_DIV cycles.

## Test plan
All scenarios use default parameters.
- Accept and range: trig high 600 cycles, dist_cm=10 → echo rises 25003 cycles after trig falls and stays high 29000 cycles. busy falls 50000 cycles after the echo fall.
- Short trigger: trig high 400 cycles → trig_err=1 for one cycle, 3 cycles after the fall. No echo; busy low again the next cycle.
- No object: dist_cm=0 → echo high 1,900,000 cycles. Repeat with dist_cm=401 → same result.
- Busy lockout: second trig pulse during ECHO, and trig held high from HOLDOFF into IDLE → echo width unchanged and no new echo. A new edge in IDLE produces a normal response.
- Reset mid-echo: resetn=0 for one cycle during ECHO → echo=0 and busy=0 from that edge. The next valid trigger behaves as in the accept-and-range scenario.
- Jitter (US_EMU_JITTER_EN): first accepted trigger after reset, dist_cm=10 → echo high 29000+5*50=29250 cycles.
